// File: rtl/bsg_manycore_out_credit_tracker.sv
// Per-tile outstanding remote-store tracker with throttling, sticky error flags
// and a fence handshake that completes once every store has been acknowledged.
module bsg_manycore_out_credit_tracker #(
  parameter int unsigned x_cord_width_p      = 4,
  parameter int unsigned y_cord_width_p      = 4,
  parameter int unsigned max_out_credits_p   = 16,
  parameter int unsigned ret_fifo_els_p      = 2,
  localparam int unsigned ret_packet_width_lp = 5 + x_cord_width_p + y_cord_width_p,
  localparam int unsigned cnt_width_lp        = $clog2(max_out_credits_p + 1)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           store_fire_i,
  output logic                           credit_avail_o,
  input  logic                           ret_v_i,
  input  logic [ret_packet_width_lp-1:0] ret_data_i,
  output logic                           ret_ready_o,
  input  logic [x_cord_width_p-1:0]      my_x_i,
  input  logic [y_cord_width_p-1:0]      my_y_i,
  input  logic                           fence_v_i,
  output logic                           fence_yumi_o,
  output logic [cnt_width_lp-1:0]        out_credits_o,
  output logic [2:0]                     err_o
);

  localparam int unsigned coord_width_lp = x_cord_width_p + y_cord_width_p;
  localparam int unsigned ptr_width_lp   = $clog2(ret_fifo_els_p);
  localparam int unsigned occ_width_lp   = $clog2(ret_fifo_els_p + 1);

  typedef enum logic [1:0] {e_idle, e_wait, e_done} state_e;

  state_e                    state_r, state_n;
  logic                      yumi_r;
  logic [cnt_width_lp-1:0]   cnt_r, cnt_n;
  logic [2:0]                err_r, err_n;

  logic [coord_width_lp-1:0] fifo_mem_r [ret_fifo_els_p];
  logic [ptr_width_lp-1:0]   rd_ptr_r, wr_ptr_r;
  logic [occ_width_lp-1:0]   occ_r;
  logic                      fifo_v, enq;
  logic [coord_width_lp-1:0] head;
  logic [4:0]                unused_pad;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(ret_fifo_els_p - 1)) ? '0 : p + ptr_width_lp'(1);
  endfunction

  // Return packets carry only coordinates of interest; the pad field is ignored.
  assign unused_pad  = ret_data_i[ret_packet_width_lp-1 -: 5];
  assign fifo_v      = (occ_r != '0);
  assign ret_ready_o = (occ_r != occ_width_lp'(ret_fifo_els_p));
  assign enq         = ret_v_i & ret_ready_o;
  assign head        = fifo_mem_r[rd_ptr_r];

  // Return buffer storage; contents are don't-care while not counted by occ_r.
  always_ff @(posedge clk_i) begin
    if (enq) fifo_mem_r[wr_ptr_r] <= ret_data_i[coord_width_lp-1:0];
  end

  // Return buffer pointers; the head is drained every cycle it is valid.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      occ_r    <= '0;
    end else begin
      if (enq)    wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (fifo_v) rd_ptr_r <= ptr_inc(rd_ptr_r);
      occ_r <= occ_r + occ_width_lp'(enq) - occ_width_lp'(fifo_v);
    end
  end

  // Credit counter and sticky error flags.
  always_comb begin
    cnt_n = cnt_r;
    err_n = err_r;
    if (fifo_v && (head != {my_y_i, my_x_i})) err_n[2] = 1'b1;
    if (store_fire_i && !fifo_v) begin
      if (cnt_r == cnt_width_lp'(max_out_credits_p)) err_n[1] = 1'b1;
      else                                           cnt_n = cnt_r + cnt_width_lp'(1);
    end else if (!store_fire_i && fifo_v) begin
      if (cnt_r == '0) err_n[0] = 1'b1;
      else             cnt_n = cnt_r - cnt_width_lp'(1);
    end
  end

  // Fence sequencing: wait for quiescence, then acknowledge once.
  always_comb begin
    state_n = state_r;
    case (state_r)
      e_idle:  if (fence_v_i) state_n = e_wait;
      e_wait:  if ((cnt_r == '0) && !store_fire_i && !fifo_v) state_n = e_done;
      e_done:  state_n = e_idle;
      default: state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_idle;
      yumi_r  <= 1'b0;
      cnt_r   <= '0;
      err_r   <= '0;
    end else begin
      state_r <= state_n;
      yumi_r  <= (state_n == e_done);
      cnt_r   <= cnt_n;
      err_r   <= err_n;
    end
  end

  assign credit_avail_o = (cnt_r < cnt_width_lp'(max_out_credits_p)) && (state_r == e_idle);
  assign fence_yumi_o   = yumi_r;
  assign out_credits_o  = cnt_r;
  assign err_o          = err_r;

endmodule

// File: tb/tb_bsg_manycore_out_credit_tracker.sv
// Scoreboard bench for bsg_manycore_out_credit_tracker: a queue-based reference
// model predicts every cycle's outputs; a monitor compares them independently.
module tb_bsg_manycore_out_credit_tracker;

  localparam int unsigned XW  = 4;
  localparam int unsigned YW  = 4;
  localparam int unsigned MAX = 4;
  localparam int unsigned ELS = 2;
  localparam int unsigned PW  = 5 + XW + YW;
  localparam int unsigned CW  = $clog2(MAX + 1);
  localparam logic [XW-1:0] MY_X = 4'd5;
  localparam logic [YW-1:0] MY_Y = 4'd9;

  logic          clk = 1'b0;
  logic          reset_i, store_fire_i, ret_v_i, fence_v_i;
  logic [PW-1:0] ret_data_i;
  logic          credit_avail_o, ret_ready_o, fence_yumi_o;
  logic [CW-1:0] out_credits_o;
  logic [2:0]    err_o;

  always #5 clk = ~clk;

  bsg_manycore_out_credit_tracker #(
    .x_cord_width_p(XW), .y_cord_width_p(YW),
    .max_out_credits_p(MAX), .ret_fifo_els_p(ELS)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .store_fire_i(store_fire_i),
    .credit_avail_o(credit_avail_o), .ret_v_i(ret_v_i), .ret_data_i(ret_data_i),
    .ret_ready_o(ret_ready_o), .my_x_i(MY_X), .my_y_i(MY_Y),
    .fence_v_i(fence_v_i), .fence_yumi_o(fence_yumi_o),
    .out_credits_o(out_credits_o), .err_o(err_o)
  );

  typedef struct {
    int cnt;
    int err;
    bit yumi;
    bit rdy;
    bit avail;
  } exp_t;

  exp_t             exp_q[$];
  int               m_cnt = 0, m_err = 0, m_phase = 0; // phase: 0 idle, 1 waiting, 2 acking
  logic [XW+YW-1:0] m_q[$];
  int               errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  function automatic logic [PW-1:0] pkt(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return {5'b0, y, x};
  endfunction

  // Drive one cycle of inputs, advance the model, queue the predicted post-edge outputs.
  task automatic step(input bit rst, input bit sf, input bit rv, input logic [PW-1:0] data,
                      input bit fv);
    exp_t             e;
    bit               dec, acc;
    logic [XW+YW-1:0] h;
    reset_i = rst; store_fire_i = sf; ret_v_i = rv; ret_data_i = data; fence_v_i = fv;
    if (rst) begin
      m_cnt = 0; m_err = 0; m_phase = 0; m_q.delete();
    end else begin
      dec = (m_q.size() > 0);
      acc = rv && (m_q.size() < int'(ELS));
      case (m_phase)
        0:       if (fv) m_phase = 1;
        1:       if (m_cnt == 0 && !sf && !dec) m_phase = 2;
        default: m_phase = 0;
      endcase
      if (dec) begin
        h = m_q.pop_front();
        if (h != {MY_Y, MY_X}) m_err |= 4;
      end
      if (sf && !dec) begin
        if (m_cnt == int'(MAX)) m_err |= 2; else m_cnt++;
      end else if (dec && !sf) begin
        if (m_cnt == 0) m_err |= 1; else m_cnt--;
      end
      if (acc) m_q.push_back(data[XW+YW-1:0]);
    end
    e.cnt = m_cnt; e.err = m_err; e.yumi = (m_phase == 2);
    e.rdy = (m_q.size() < int'(ELS)); e.avail = (m_cnt < int'(MAX)) && (m_phase == 0);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: compare DUT outputs against the oldest prediction after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_out_credits", 32'(out_credits_o), e.cnt);
        chk("sb_err", 32'(err_o), e.err);
        chk("sb_fence_yumi", 32'(fence_yumi_o), 32'(e.yumi));
        chk("sb_ret_ready", 32'(ret_ready_o), 32'(e.rdy));
        chk("sb_credit_avail", 32'(credit_avail_o), 32'(e.avail));
      end
    end
  end

  initial begin
    logic [PW-1:0] good, bad;
    int            n;
    good = pkt(MY_X, MY_Y);
    bad  = pkt(MY_X + 4'd1, MY_Y);

    step(1, 0, 0, good, 0);
    step(1, 0, 0, good, 0);
    chk("rst_count", 32'(out_credits_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_ready", 32'(ret_ready_o), 1);
    chk("rst_avail", 32'(credit_avail_o), 1);

    // Count up then drain with correctly addressed returns.
    for (int i = 1; i <= 3; i++) begin
      step(0, 1, 0, good, 0);
      chk("count_up", 32'(out_credits_o), 32'(i));
    end
    for (int i = 0; i < 3; i++) step(0, 0, 1, good, 0);
    step(0, 0, 0, good, 0);
    chk("drain_count", 32'(out_credits_o), 0);
    chk("drain_err", 32'(err_o), 0);

    // Limit and overflow.
    for (int i = 0; i < 4; i++) step(0, 1, 0, good, 0);
    chk("limit_count", 32'(out_credits_o), 4);
    chk("limit_avail", 32'(credit_avail_o), 0);
    step(0, 1, 0, good, 0);
    chk("ovf_count", 32'(out_credits_o), 4);
    chk("ovf_err", 32'(err_o), 3'b010);
    step(1, 0, 0, good, 0);

    // Store and dequeue in the same cycle.
    step(0, 1, 0, good, 0);
    step(0, 1, 0, good, 0);
    step(0, 0, 1, good, 0);
    step(0, 1, 0, good, 0);
    chk("simul_count", 32'(out_credits_o), 2);
    step(1, 0, 0, good, 0);

    // Fence with two stores pending.
    step(0, 1, 0, good, 0);
    step(0, 1, 0, good, 0);
    step(0, 0, 0, good, 1);
    chk("fence_avail_blocked", 32'(credit_avail_o), 0);
    step(0, 0, 1, good, 1);
    step(0, 0, 1, good, 1);
    n = 0;
    while (!fence_yumi_o && n < 20) begin
      step(0, 0, 0, good, 1);
      n++;
    end
    chk("fence_yumi_seen", 32'(fence_yumi_o), 1);
    chk("fence_count", 32'(out_credits_o), 0);
    step(0, 0, 0, good, 0);
    chk("fence_yumi_pulse", 32'(fence_yumi_o), 0);
    chk("fence_avail_back", 32'(credit_avail_o), 1);

    // Underflow, then misroute.
    step(1, 0, 0, good, 0);
    step(0, 0, 1, good, 0);
    step(0, 0, 0, good, 0);
    chk("unf_err", 32'(err_o), 3'b001);
    chk("unf_count", 32'(out_credits_o), 0);
    step(0, 1, 0, good, 0);
    step(0, 0, 1, bad, 0);
    step(0, 0, 0, good, 0);
    chk("misroute_err", 32'(err_o), 3'b101);
    chk("misroute_count", 32'(out_credits_o), 0);

    // Back-to-back returns never backpressure; reset mid-stream discards them.
    step(1, 0, 0, good, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, good, 0);
      chk("bp_ready", 32'(ret_ready_o), 1);
    end
    step(1, 0, 1, good, 0);
    chk("midrst_count", 32'(out_credits_o), 0);
    chk("midrst_err", 32'(err_o), 0);
    chk("midrst_ready", 32'(ret_ready_o), 1);
    step(0, 0, 0, good, 0);
    chk("midrst_flushed", 32'(err_o), 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit sf;
      sf = credit_avail_o ? bit'($urandom_range(1, 0)) : ($urandom_range(15, 0) == 0);
      step(($urandom_range(199, 0) == 0), sf, bit'($urandom_range(1, 0)),
           ($urandom_range(31, 0) == 0) ? bad : good, ($urandom_range(7, 0) == 0));
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, good, 0);
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
